// File: rtl/axi_time_trig_core.sv
// Timestamp engine: free-running time counter plus NUM_CH independent channels,
// each with an edge-triggered capture register and a compare-based trigger generator.
module axi_time_trig_core #(
    parameter int TIME_WIDTH = 64,
    parameter int NUM_CH     = 2,
    parameter int PULSE_BITS = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          time_enable,
    input  logic                          time_ovwr_req,
    input  logic [TIME_WIDTH-1:0]         time_ovwr_value,
    output logic [TIME_WIDTH-1:0]         time_counter,
    input  logic [NUM_CH-1:0]             capt_in,
    input  logic [NUM_CH-1:0]             capt_clr,
    output logic [NUM_CH*TIME_WIDTH-1:0]  capt_value,
    output logic [NUM_CH-1:0]             capt_valid,
    input  logic [NUM_CH-1:0]             trig_arm,
    input  logic [NUM_CH-1:0]             trig_disarm,
    input  logic [NUM_CH-1:0]             trig_periodic,
    input  logic [NUM_CH*TIME_WIDTH-1:0]  trig_time,
    input  logic [NUM_CH*TIME_WIDTH-1:0]  trig_period,
    input  logic [NUM_CH*PULSE_BITS-1:0]  trig_pulse_len,
    output logic [NUM_CH-1:0]             trig_out,
    output logic [NUM_CH-1:0]             trig_armed,
    output logic [NUM_CH-1:0]             trig_late
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRE  = 2'd2
    } trig_state_t;

    localparam logic [PULSE_BITS-1:0] PULSE_ONE = PULSE_BITS'(1);

    logic [TIME_WIDTH-1:0] time_reg;

    // Overwrite has priority over counting
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            time_reg <= '0;
        end else if (time_ovwr_req) begin
            time_reg <= time_ovwr_value;
        end else if (time_enable) begin
            time_reg <= time_reg + TIME_WIDTH'(1);
        end
    end

    assign time_counter = time_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic                  prev_reg;
            logic                  edge_det;
            logic [TIME_WIDTH-1:0] capt_value_reg;
            logic                  capt_valid_reg;

            // Previous sample resets high so a level already present at reset is not an edge
            assign edge_det = capt_in[gi] & ~prev_reg;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    prev_reg       <= 1'b1;
                    capt_value_reg <= '0;
                    capt_valid_reg <= 1'b0;
                end else begin
                    prev_reg <= capt_in[gi];
                    if (edge_det && (!capt_valid_reg || capt_clr[gi])) begin
                        capt_value_reg <= time_reg;
                        capt_valid_reg <= 1'b1;
                    end else if (capt_clr[gi]) begin
                        capt_valid_reg <= 1'b0;
                    end
                end
            end

            assign capt_value[gi*TIME_WIDTH +: TIME_WIDTH] = capt_value_reg;
            assign capt_valid[gi]                          = capt_valid_reg;

            trig_state_t           state_reg, state_next;
            logic [TIME_WIDTH-1:0] target_reg, target_next;
            logic [PULSE_BITS-1:0] pcnt_reg, pcnt_next;
            logic                  late_reg, late_next;
            logic [TIME_WIDTH-1:0] ch_time, ch_period, arm_delta;
            logic [PULSE_BITS-1:0] ch_len, len_eff;
            logic                  arm_late, hit;

            assign ch_time   = trig_time[gi*TIME_WIDTH +: TIME_WIDTH];
            assign ch_period = trig_period[gi*TIME_WIDTH +: TIME_WIDTH];
            assign ch_len    = trig_pulse_len[gi*PULSE_BITS +: PULSE_BITS];
            assign len_eff   = (ch_len == '0) ? PULSE_ONE : ch_len;
            // A target equal to now or in the past half of the time circle is late
            assign arm_delta = ch_time - time_reg;
            assign arm_late  = (arm_delta == '0) || arm_delta[TIME_WIDTH-1];
            assign hit       = (time_reg == target_reg);

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state_reg  <= ST_IDLE;
                    target_reg <= '0;
                    pcnt_reg   <= '0;
                    late_reg   <= 1'b0;
                end else begin
                    state_reg  <= state_next;
                    target_reg <= target_next;
                    pcnt_reg   <= pcnt_next;
                    late_reg   <= late_next;
                end
            end

            always_comb begin
                state_next  = state_reg;
                target_next = target_reg;
                pcnt_next   = pcnt_reg;
                late_next   = late_reg;
                if (trig_disarm[gi]) begin
                    state_next = ST_IDLE;
                end else if (trig_arm[gi]) begin
                    if (arm_late) begin
                        late_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        target_next = ch_time;
                        late_next   = 1'b0;
                        state_next  = ST_ARMED;
                    end
                end else begin
                    case (state_reg)
                        ST_ARMED: begin
                            if (hit) begin
                                state_next = ST_FIRE;
                                pcnt_next  = len_eff;
                                if (trig_periodic[gi]) begin
                                    target_next = target_reg + ch_period;
                                end
                            end
                        end
                        ST_FIRE: begin
                            // A periodic hit during a pulse restarts it, merging overlaps
                            if (trig_periodic[gi] && hit) begin
                                pcnt_next   = len_eff;
                                target_next = target_reg + ch_period;
                            end else begin
                                pcnt_next = pcnt_reg - PULSE_ONE;
                                if (pcnt_reg <= PULSE_ONE) begin
                                    state_next = trig_periodic[gi] ? ST_ARMED : ST_IDLE;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end

            assign trig_out[gi]   = (state_reg == ST_FIRE);
            assign trig_armed[gi] = (state_reg != ST_IDLE);
            assign trig_late[gi]  = late_reg;
        end
    endgenerate

endmodule

// File: tb/tb_axi_time_trig_core.sv
// Self-checking bench for axi_time_trig_core: directed scenarios then random traffic,
// every cycle compared against a behavioural model of counter, capture and triggers.
module tb_axi_time_trig_core;

    localparam int TW  = 64;
    localparam int NCH = 2;
    localparam int PB  = 8;
    localparam logic [TW-1:0] HALF = 64'h8000_0000_0000_0000;

    logic               clk = 1'b0;
    logic               resetn;
    logic               time_enable;
    logic               time_ovwr_req;
    logic [TW-1:0]      time_ovwr_value;
    logic [TW-1:0]      time_counter;
    logic [NCH-1:0]     capt_in, capt_clr;
    logic [NCH*TW-1:0]  capt_value;
    logic [NCH-1:0]     capt_valid;
    logic [NCH-1:0]     trig_arm, trig_disarm, trig_periodic;
    logic [NCH*TW-1:0]  trig_time, trig_period;
    logic [NCH*PB-1:0]  trig_pulse_len;
    logic [NCH-1:0]     trig_out, trig_armed, trig_late;

    axi_time_trig_core #(.TIME_WIDTH(TW), .NUM_CH(NCH), .PULSE_BITS(PB)) dut (
        .clk(clk), .resetn(resetn),
        .time_enable(time_enable), .time_ovwr_req(time_ovwr_req),
        .time_ovwr_value(time_ovwr_value), .time_counter(time_counter),
        .capt_in(capt_in), .capt_clr(capt_clr),
        .capt_value(capt_value), .capt_valid(capt_valid),
        .trig_arm(trig_arm), .trig_disarm(trig_disarm), .trig_periodic(trig_periodic),
        .trig_time(trig_time), .trig_period(trig_period), .trig_pulse_len(trig_pulse_len),
        .trig_out(trig_out), .trig_armed(trig_armed), .trig_late(trig_late)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: each channel is "waiting for target" and has a count of pulse cycles still owed
    logic [TW-1:0] m_time;
    logic          m_prev   [NCH];
    logic [TW-1:0] m_cval   [NCH];
    logic          m_cvalid [NCH];
    logic [TW-1:0] m_target [NCH];
    logic          m_wait   [NCH];
    logic          m_late   [NCH];
    int            m_rem    [NCH];

    task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_time = '0;
        for (int c = 0; c < NCH; c++) begin
            m_prev[c] = 1'b1; m_cval[c] = '0; m_cvalid[c] = 1'b0;
            m_target[c] = '0; m_wait[c] = 1'b0; m_late[c] = 1'b0; m_rem[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [TW-1:0] t_old, tt, d;
        int nr, len;
        if (!resetn) begin
            model_reset();
            return;
        end
        t_old = m_time;
        for (int c = 0; c < NCH; c++) begin
            if (capt_in[c] && !m_prev[c] && (!m_cvalid[c] || capt_clr[c])) begin
                m_cval[c] = t_old; m_cvalid[c] = 1'b1;
            end else if (capt_clr[c]) begin
                m_cvalid[c] = 1'b0;
            end
            m_prev[c] = capt_in[c];

            tt  = trig_time[c*TW +: TW];
            d   = tt - t_old;
            len = int'(trig_pulse_len[c*PB +: PB]);
            if (len == 0) len = 1;
            if (trig_disarm[c]) begin
                m_wait[c] = 1'b0; m_rem[c] = 0;
            end else if (trig_arm[c]) begin
                if (d == 0 || d >= HALF) begin
                    m_late[c] = 1'b1; m_wait[c] = 1'b0; m_rem[c] = 0;
                end else begin
                    m_target[c] = tt; m_late[c] = 1'b0; m_wait[c] = 1'b1; m_rem[c] = 0;
                end
            end else begin
                nr = (m_rem[c] > 0) ? m_rem[c] - 1 : 0;
                if (m_wait[c] && t_old == m_target[c]) begin
                    nr = len;
                    if (trig_periodic[c]) m_target[c] = m_target[c] + trig_period[c*TW +: TW];
                    else m_wait[c] = 1'b0;
                end
                m_rem[c] = nr;
            end
        end
        if (time_ovwr_req) m_time = time_ovwr_value;
        else if (time_enable) m_time = m_time + 1;
    endtask

    task automatic check_all();
        chk("time_counter", time_counter, m_time);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("capt_value[%0d]", c), capt_value[c*TW +: TW], m_cval[c]);
            chk($sformatf("capt_valid[%0d]", c), TW'(capt_valid[c]), TW'(m_cvalid[c]));
            chk($sformatf("trig_out[%0d]", c), TW'(trig_out[c]), TW'(m_rem[c] > 0));
            chk($sformatf("trig_armed[%0d]", c), TW'(trig_armed[c]), TW'(m_wait[c] || m_rem[c] > 0));
            chk($sformatf("trig_late[%0d]", c), TW'(trig_late[c]), TW'(m_late[c]));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        time_ovwr_req = 1'b0; capt_clr = '0; trig_arm = '0; trig_disarm = '0;
    endtask

    task automatic ovwr(input logic [TW-1:0] v);
        time_ovwr_req = 1'b1; time_ovwr_value = v;
        tick();
    endtask

    task automatic set_arm(input int c, input logic [TW-1:0] tt, input int len,
                           input logic [TW-1:0] per);
        trig_time[c*TW +: TW]      = tt;
        trig_pulse_len[c*PB +: PB] = PB'(len);
        trig_period[c*TW +: TW]    = per;
        trig_arm[c]                = 1'b1;
    endtask

    initial begin
        bit seen;
        resetn = 1'b0; time_enable = 1'b0; time_ovwr_req = 1'b0; time_ovwr_value = '0;
        capt_in = '0; capt_clr = '0; trig_arm = '0; trig_disarm = '0; trig_periodic = '0;
        trig_time = '0; trig_period = '0; trig_pulse_len = '0;
        model_reset();

        // Reset and counting
        tick(); tick();
        chk("reset_time", time_counter, 0);
        resetn = 1'b1; time_enable = 1'b1;
        tick(); tick(); tick();
        chk("count_3", time_counter, 3);
        ovwr(64'hFFFF_FFFF_FFFF_FFFE);
        chk("ovwr_fe", time_counter, 64'hFFFF_FFFF_FFFF_FFFE);
        tick(); chk("ovwr_ff", time_counter, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(); chk("wrap_0", time_counter, 0);

        // Capture on channel 1
        ovwr(100);
        capt_in[1] = 1'b1; tick();
        chk("capt_100", capt_value[TW +: TW], 100);
        chk("capt_valid_100", TW'(capt_valid[1]), 1);
        capt_in[1] = 1'b0; ovwr(200);
        capt_in[1] = 1'b1; tick();
        chk("capt_ignored", capt_value[TW +: TW], 100);
        capt_in[1] = 1'b0; ovwr(300);
        capt_in[1] = 1'b1; capt_clr[1] = 1'b1; tick();
        chk("capt_clr_edge", capt_value[TW +: TW], 300);
        chk("capt_clr_edge_valid", TW'(capt_valid[1]), 1);
        capt_in[1] = 1'b0; capt_clr[1] = 1'b1; tick();
        chk("capt_cleared", TW'(capt_valid[1]), 0);

        // One-shot, pulse_len 3 then 0
        ovwr(10);
        set_arm(0, 50, 3, 0); tick();
        chk("oneshot_armed", TW'(trig_armed[0]), 1);
        for (int k = 0; k < 44; k++) begin
            tick();
            chk("oneshot_out", TW'(trig_out[0]), TW'(m_time >= 51 && m_time <= 53));
        end
        chk("oneshot_done", TW'(trig_armed[0]), 0);
        set_arm(0, 60, 0, 0); tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("len0_out", TW'(trig_out[0]), TW'(m_time == 61));
        end

        // Periodic on channel 1
        ovwr(10);
        trig_periodic[1] = 1'b1;
        set_arm(1, 20, 2, 10); tick();
        for (int k = 0; k < 39; k++) begin
            tick();
            chk("periodic_out", TW'(trig_out[1]), TW'(m_time > 20 && (m_time - 21) % 10 < 2));
        end
        set_arm(1, m_time + 4, 4, 2); tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("continuous_out", TW'(trig_out[1]), TW'(m_time > 54));
        end
        trig_disarm[1] = 1'b1; trig_periodic[1] = 1'b0; tick();
        chk("disarm_out", TW'(trig_out[1]), 0);

        // Late arm and re-arm
        ovwr(1000);
        set_arm(0, 1000, 0, 0); tick();
        chk("late_eq", TW'(trig_late[0]), 1);
        chk("late_eq_armed", TW'(trig_armed[0]), 0);
        set_arm(0, 900, 0, 0); tick();
        chk("late_past", TW'(trig_late[0]), 1);
        set_arm(0, 1100, 0, 0); tick();
        chk("late_cleared", TW'(trig_late[0]), 0);
        for (int k = 0; k < 99; k++) begin
            tick();
            chk("rearm_out", TW'(trig_out[0]), TW'(m_time == 1101));
        end

        // Arm across the counter wrap
        ovwr(64'hFFFF_FFFF_FFFF_FFF0);
        set_arm(0, 5, 1, 0); tick();
        for (int k = 0; k < 22; k++) begin
            tick();
            chk("wrap_out", TW'(trig_out[0]), TW'(m_time == 6));
        end

        // Overwrite past the target: stays armed, never fires
        set_arm(0, 20, 1, 0); tick();
        ovwr(30);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("skip_armed", TW'(trig_armed[0]), 1);
            chk("skip_out", TW'(trig_out[0]), 0);
        end
        trig_disarm[0] = 1'b1; tick();

        // Asynchronous reset in the middle of a pulse
        set_arm(0, m_time + 3, 8, 0); tick();
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = trig_out[0];
        end
        chk("fire_seen", TW'(seen), 1);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("async_rst_out", TW'(trig_out[0]), 0);
        check_all();
        tick();
        resetn = 1'b1;

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            time_enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 99) == 0) begin
                time_ovwr_req   = 1'b1;
                time_ovwr_value = m_time + TW'($urandom_range(0, 40)) - TW'(20);
            end
            capt_in = NCH'($urandom);
            for (int c = 0; c < NCH; c++) begin
                capt_clr[c] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 39) == 0) begin
                    trig_disarm[c]   = 1'b1;
                    trig_periodic[c] = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 14) == 0)
                    set_arm(c, m_time + TW'($urandom_range(0, 60)) - TW'(10),
                            int'($urandom_range(0, 5)), TW'($urandom_range(1, 12)));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
